// File: rtl/count_monitor.sv
// count_monitor: passive checker for a free-running modulo-2^WIDTH counter.
// It locks onto the increment sequence, then classifies each sample as a wrap,
// a restart or an error, and keeps saturating statistics for each event kind.
//
// Handshake: cnt_valid qualifies cnt_in for the cycle it is high. There is no
// ready or backpressure because the monitor can accept a sample on every cycle.
module count_monitor #(
    parameter int WIDTH  = 3,
    parameter int LOCK_N = 2,
    parameter int STAT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              cnt_valid,
    input  logic              clr,
    output logic              locked,
    output logic              wrap_pulse,
    output logic              restart_pulse,
    output logic              err_pulse,
    output logic [STAT_W-1:0] wrap_count,
    output logic [STAT_W-1:0] restart_count,
    output logic [STAT_W-1:0] err_count,
    output logic [WIDTH-1:0]  last_val,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;
    localparam logic [3:0]        LOCK_N_4 = 4'(LOCK_N);

    state_t            state_q;
    logic [3:0]        run_q;
    logic [WIDTH-1:0]  last_val_q;
    logic              wrap_pulse_q, restart_pulse_q, err_pulse_q;
    logic [STAT_W-1:0] wrap_cnt_q, restart_cnt_q, err_cnt_q;
    logic [STAT_W-1:0] wrap_cnt_d, restart_cnt_d, err_cnt_d;

    logic [WIDTH-1:0]  exp_val;
    logic [3:0]        run_inc;
    logic              match;
    logic              wrap_ev, restart_ev, err_ev;

    // Event decode for the current sample and next values of the statistics.
    always_comb begin
        exp_val    = WIDTH'(last_val_q + 1'b1);
        run_inc    = 4'(run_q + 4'd1);
        match      = (cnt_in == exp_val);
        wrap_ev    = cnt_valid && (state_q == S_LOCKED) && match && (last_val_q == CNT_MAX);
        restart_ev = cnt_valid && (state_q == S_LOCKED) && !match && (cnt_in == '0);
        err_ev     = cnt_valid && (state_q == S_LOCKED) && !match && (cnt_in != '0);

        wrap_cnt_d    = wrap_cnt_q;
        restart_cnt_d = restart_cnt_q;
        err_cnt_d     = err_cnt_q;
        if (clr) begin
            // clr wins over any increment in the same cycle
            wrap_cnt_d    = '0;
            restart_cnt_d = '0;
            err_cnt_d     = '0;
        end else begin
            if (wrap_ev && wrap_cnt_q != STAT_MAX)
                wrap_cnt_d = STAT_W'(wrap_cnt_q + 1'b1);
            if (restart_ev && restart_cnt_q != STAT_MAX)
                restart_cnt_d = STAT_W'(restart_cnt_q + 1'b1);
            if (err_ev && err_cnt_q != STAT_MAX)
                err_cnt_d = STAT_W'(err_cnt_q + 1'b1);
        end
    end

    // Lock FSM, sample register, registered pulses and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_EMPTY;
            run_q           <= '0;
            last_val_q      <= '0;
            wrap_pulse_q    <= 1'b0;
            restart_pulse_q <= 1'b0;
            err_pulse_q     <= 1'b0;
            wrap_cnt_q      <= '0;
            restart_cnt_q   <= '0;
            err_cnt_q       <= '0;
        end else begin
            wrap_pulse_q    <= wrap_ev;
            restart_pulse_q <= restart_ev;
            err_pulse_q     <= err_ev;
            wrap_cnt_q      <= wrap_cnt_d;
            restart_cnt_q   <= restart_cnt_d;
            err_cnt_q       <= err_cnt_d;
            if (cnt_valid) begin
                last_val_q <= cnt_in;
                case (state_q)
                    S_EMPTY: begin
                        state_q <= S_ACQUIRE;
                        run_q   <= '0;
                    end
                    S_ACQUIRE: begin
                        if (!match) begin
                            run_q <= '0;
                        end else if (run_inc == LOCK_N_4) begin
                            state_q <= S_LOCKED;
                            run_q   <= '0;
                        end else begin
                            run_q <= run_inc;
                        end
                    end
                    S_LOCKED: begin
                        // any mismatch (restart or error) drops back to acquisition
                        if (!match) begin
                            state_q <= S_ACQUIRE;
                            run_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= S_EMPTY;
                        run_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign locked        = (state_q == S_LOCKED);
    assign wrap_pulse    = wrap_pulse_q;
    assign restart_pulse = restart_pulse_q;
    assign err_pulse     = err_pulse_q;
    assign wrap_count    = wrap_cnt_q;
    assign restart_count = restart_cnt_q;
    assign err_count     = err_cnt_q;
    assign last_val      = last_val_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: a behavioural reference model predicts every
// output after each clock; predictions are queued and compared once the edge
// has produced them, plus directed checks against hand-derived constants.
module tb_count_monitor;

  localparam int WIDTH  = 3;
  localparam int LOCK_N = 2;
  localparam int STAT_W = 8;
  localparam int SB_W   = 4 + 3 * STAT_W + WIDTH + 2;

  logic              clk;
  logic              rst;
  logic [WIDTH-1:0]  cnt_in;
  logic              cnt_valid;
  logic              clr;
  logic              locked;
  logic              wrap_pulse;
  logic              restart_pulse;
  logic              err_pulse;
  logic [STAT_W-1:0] wrap_count;
  logic [STAT_W-1:0] restart_count;
  logic [STAT_W-1:0] err_count;
  logic [WIDTH-1:0]  last_val;
  logic [1:0]        dbg_state;

  count_monitor #(.WIDTH(WIDTH), .LOCK_N(LOCK_N), .STAT_W(STAT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cnt_in        (cnt_in),
    .cnt_valid     (cnt_valid),
    .clr           (clr),
    .locked        (locked),
    .wrap_pulse    (wrap_pulse),
    .restart_pulse (restart_pulse),
    .err_pulse     (err_pulse),
    .wrap_count    (wrap_count),
    .restart_count (restart_count),
    .err_count     (err_count),
    .last_val      (last_val),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [SB_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // reference model state (0 = empty, 1 = acquire, 2 = locked)
  int              m_state = 0;
  int              m_run   = 0;
  logic [WIDTH-1:0] m_last = '0;
  logic            m_wrap = 0, m_restart = 0, m_err = 0;
  int              m_wc = 0, m_rc = 0, m_ec = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= (1 << STAT_W) - 1) ? v : v + 1;
  endfunction

  function automatic logic [SB_W-1:0] model_vec();
    return {m_state == 2, m_wrap, m_restart, m_err,
            STAT_W'(m_wc), STAT_W'(m_rc), STAT_W'(m_ec), m_last, 2'(m_state)};
  endfunction

  function automatic logic [SB_W-1:0] dut_vec();
    return {locked, wrap_pulse, restart_pulse, err_pulse,
            wrap_count, restart_count, err_count, last_val, dbg_state};
  endfunction

  // Predict the outputs produced by the coming edge.
  task automatic model_step(input logic v, input logic [WIDTH-1:0] val, input logic c, input logic r);
    logic [WIDTH-1:0] nxt;
    if (r) begin
      m_state = 0; m_run = 0; m_last = '0;
      m_wrap = 0; m_restart = 0; m_err = 0;
      m_wc = 0; m_rc = 0; m_ec = 0;
      return;
    end
    m_wrap = 0; m_restart = 0; m_err = 0;
    if (v) begin
      nxt = WIDTH'(m_last + 1);
      if (m_state == 0) begin
        m_state = 1; m_run = 0;
      end else if (m_state == 1) begin
        if (val != nxt) m_run = 0;
        else if (m_run + 1 == LOCK_N) begin m_state = 2; m_run = 0; end
        else m_run = m_run + 1;
      end else begin
        if (val == nxt) m_wrap = (m_last == '1);
        else begin
          if (val == 0) m_restart = 1; else m_err = 1;
          m_state = 1; m_run = 0;
        end
      end
      m_last = val;
    end
    if (c) begin
      m_wc = 0; m_rc = 0; m_ec = 0;
    end else begin
      if (m_wrap)    m_wc = sat_inc(m_wc);
      if (m_restart) m_rc = sat_inc(m_rc);
      if (m_err)     m_ec = sat_inc(m_ec);
    end
  endtask

  // driver: one clock with the given inputs, then score the result
  task automatic drive(input logic v, input logic [WIDTH-1:0] val, input logic c, input logic r);
    logic [SB_W-1:0] e;
    @(negedge clk);
    cnt_valid = v; cnt_in = val; clr = c; rst = r;
    model_step(v, val, c, r);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("scoreboard", 64'(dut_vec()), 64'(e));
  endtask

  task automatic sample(input logic [WIDTH-1:0] val);
    drive(1'b1, val, 1'b0, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] rv;
    rst = 1'b1; cnt_in = '0; cnt_valid = 1'b0; clr = 1'b0;

    // reset
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    check("reset_locked", 64'(locked), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(0));
    check("reset_counts", 64'({wrap_count, restart_count, err_count}), 64'(0));

    // lock and wrap
    sample(3'd5); sample(3'd6);
    check("not_locked_yet", 64'(locked), 64'(0));
    sample(3'd7);
    check("locked_after_7", 64'(locked), 64'(1));
    sample(3'd0);
    check("wrap_pulse", 64'(wrap_pulse), 64'(1));
    check("wrap_count_1", 64'(wrap_count), 64'(1));
    sample(3'd1);
    check("wrap_pulse_off", 64'(wrap_pulse), 64'(0));
    check("err_count_0", 64'(err_count), 64'(0));

    // restart detection
    sample(3'd2); sample(3'd3); sample(3'd4);
    sample(3'd0);
    check("restart_pulse", 64'(restart_pulse), 64'(1));
    check("restart_unlock", 64'(locked), 64'(0));
    sample(3'd1);
    check("restart_pulse_off", 64'(restart_pulse), 64'(0));
    sample(3'd2);
    check("relock", 64'(locked), 64'(1));
    check("restart_count_1", 64'(restart_count), 64'(1));
    sample(3'd3);

    // error on a held value
    sample(3'd4);
    sample(3'd4);
    check("err_pulse_hold", 64'(err_pulse), 64'(1));
    check("err_count_1", 64'(err_count), 64'(1));
    check("err_unlock", 64'(locked), 64'(0));
    sample(3'd6);
    check("acq_mismatch_no_pulse", 64'({wrap_pulse, restart_pulse, err_pulse}), 64'(0));
    check("err_count_still_1", 64'(err_count), 64'(1));

    // valid gating
    sample(3'd0); sample(3'd1); sample(3'd2);
    check("gate_locked", 64'(locked), 64'(1));
    drive(1'b0, 3'd5, 1'b0, 1'b0);
    drive(1'b0, 3'd1, 1'b0, 1'b0);
    drive(1'b0, 3'd6, 1'b0, 1'b0);
    check("gate_last_val", 64'(last_val), 64'(2));
    check("gate_still_locked", 64'(locked), 64'(1));
    sample(3'd3);
    check("gate_accept", 64'({locked, wrap_pulse, restart_pulse, err_pulse, last_val}), 64'({4'b1000, 3'd3}));

    // saturation: 260 errors, each followed by a relock
    cur = 3'd3;
    for (int i = 0; i < 260; i++) begin
      sample(cur);
      sample(WIDTH'(cur + 1));
      sample(WIDTH'(cur + 2));
      cur = WIDTH'(cur + 2);
    end
    check("err_saturated", 64'(err_count), 64'(255));

    // clr in the same cycle as a wrap
    sample(3'd4); sample(3'd5); sample(3'd6); sample(3'd7);
    drive(1'b1, 3'd0, 1'b1, 1'b0);
    check("clr_wrap_pulse", 64'(wrap_pulse), 64'(1));
    check("clr_wrap_count", 64'(wrap_count), 64'(0));
    check("clr_err_count", 64'(err_count), 64'(0));
    check("clr_keeps_lock", 64'(locked), 64'(1));

    // three wraps, then reset mid-stream with a valid sample present
    for (int w = 0; w < 3; w++)
      for (int k = 1; k <= 8; k++) sample(WIDTH'(k));
    check("wrap_count_3", 64'(wrap_count), 64'(3));
    drive(1'b1, 3'd1, 1'b0, 1'b1);
    check("midrst_all_zero", 64'(dut_vec()), 64'(0));
    sample(3'd2); sample(3'd3);
    check("midrst_not_locked", 64'(locked), 64'(0));
    sample(3'd4);
    check("midrst_relock", 64'(locked), 64'(1));

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 3) != 0) ? WIDTH'(m_last + 1) : WIDTH'($urandom_range(0, 7));
      drive(($urandom_range(0, 3) != 0), rv, ($urandom_range(0, 31) == 0), ($urandom_range(0, 127) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
# count_monitor

Downstream checker for the free-running 3-bit counter. Samples the counter's output, locks onto the modulo-2^WIDTH increment sequence, and then flags each sample as a wrap, a restart or an error. Keeps saturating statistics for each kind of event. It is a pure observer: it never drives the counter, and it sits between the counter output and the debug/status register bank.

## Interface
Parameters:
- WIDTH, 3, width of the observed count
- LOCK_N, 2, number of consecutive correct increments needed to enter LOCKED (range 1..15)
- STAT_W, 8, width of each statistics counter

Ports:
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- cnt_in  in  WIDTH  observed counter value
- cnt_valid  in  1  cnt_in is sampled only in cycles where this is high
- clr  in  1  synchronous clear of the statistics counters only
- locked  out  1  high while in LOCKED
- wrap_pulse  out  1  one-cycle pulse: correct increment from max (all ones) to 0 while LOCKED
- restart_pulse  out  1  one-cycle pulse: sample 0 while LOCKED, where the previous sample was not max
- err_pulse  out  1  one-cycle pulse: any other mismatch while LOCKED
- wrap_count  out  STAT_W  saturating number of wraps
- restart_count  out  STAT_W  saturating number of restarts
- err_count  out  STAT_W  saturating number of errors
- last_val  out  WIDTH  last sampled cnt_in

## Operation
- Expected value: exp = (last_val + 1) mod 2^WIDTH, computed in WIDTH bits with natural truncation. A sample "matches" when cnt_in == exp.
- Every valid sample loads last_val <= cnt_in, in every state.
- The run counter is 4 bits wide.
- State machine (3 states):
  - EMPTY: no reference sample held yet. On a valid sample: go to ACQUIRE, run = 0.
  - ACQUIRE:
    - Valid match: run = run + 1. When run + 1 == LOCK_N, go to LOCKED and clear run.
    - Valid mismatch: run = 0, stay in ACQUIRE. Nothing is counted.
  - LOCKED:
    - Valid match with last_val == max: wrap_pulse, wrap_count + 1. Stay in LOCKED.
    - Valid match otherwise: no event. Stay in LOCKED.
    - Valid sample equal to 0 that does not match: restart_pulse, restart_count + 1. Go to ACQUIRE, run = 0.
    - Any other valid mismatch, including a held value (cnt_in == last_val): err_pulse, err_count + 1. Go to ACQUIRE, run = 0.
- When cnt_valid is low: no state change, no pulses, last_val holds.
- Statistics counters saturate at 2^STAT_W - 1 and never wrap.
- clr:
  - Zeroes all three statistics counters in the same edge, and has priority over an increment in that same cycle.
  - The pulse for that cycle's event is still asserted.
  - The FSM and last_val are unaffected.
- rst: forces EMPTY and clears run, last_val, all pulses and all counters. It overrides clr and cnt_valid.

## Timing
- Reset value of every output is 0; the FSM resets to EMPTY.
- All outputs are registered. A sample at edge N produces its pulses, counter updates, locked change and last_val at edge N (visible in cycle N+1). Latency is 1 cycle.
- Pulses are exactly one cycle wide. At most one of wrap_pulse, restart_pulse, err_pulse is high in any cycle.
- The fastest lock is LOCK_N + 1 consecutive valid samples after EMPTY. locked rises after the (LOCK_N+1)-th sample.
- locked falls in the same cycle that restart_pulse or err_pulse asserts.
- rst asserted mid-stream: on the next edge all outputs are 0. The sample present during the rst cycle is discarded.

## Test plan
- Lock and wrap:
  - Stimulus: rst for 2 cycles, then cnt_valid = 1 every cycle with cnt_in = 5,6,7,0,1.
  - Response: locked rises after the sample 7. wrap_pulse is high for exactly the one cycle after the sample 0. wrap_count = 1, err_count = 0.
- Restart detection:
  - Stimulus: locked on sequence 1,2,3,4, then cnt_in = 0, 1, 2, 3.
  - Response: restart_pulse for one cycle after the 0, locked drops to 0. Relock after sample 2 (LOCK_N = 2). restart_count = 1, err_count = 0.
- Error and hold:
  - Stimulus: locked on 2,3,4, then cnt_in = 4 (hold), then 6.
  - Response: err_pulse after the hold, err_count = 1, locked = 0. The 6 is a mismatch in ACQUIRE: run = 0, no pulse, err_count stays 1.
- Valid gating:
  - Stimulus: locked on 0,1,2, then cnt_valid low for 3 cycles while cnt_in shows garbage (5,1,6), then valid 3.
  - Response: no pulses, locked stays 1, last_val stays 2 during the gap, then 3 is accepted with no event.
- Saturation and clr priority:
  - Stimulus: force 260 errors with STAT_W = 8.
  - Response: err_count holds at 255.
  - Stimulus: assert clr in the same cycle as a wrap.
  - Response: wrap_pulse = 1 and wrap_count = 0 on the next cycle.
- Reset mid-operation:
  - Stimulus: while locked with wrap_count = 3, assert rst for 1 cycle with cnt_valid high.
  - Response: next cycle, every output is 0 and the FSM is EMPTY. The following 3 valid correct samples relock.
